benes_cfg_sequencer: RTL and testbench

Upstream feeder for the `benes` distribution network. It buffers (data vector, mux configuration, repeat count) entries in a small FIFO and drives `i_data_bus`/`i_mux_bus` of the Benes network one entry at a time. Each entry is held for 1+repeat cycles, so a single configuration can be reused across several consecutive cycles. It gives the controller a valid/ready interface in place of hard-wired per-cycle configuration words.

---
 rtl/benes_cfg_sequencer.sv | 149 ++++++++++++++
 tb/tb_benes_cfg_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/benes_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : benes_cfg_sequencer
// Purpose  : FIFO-buffered feeder that issues (data, mux config) entries to a
//            Benes network, holding each for 1+repeat cycles.
// Options  : BENES_CFG_SEQ_PERF_EN adds the o_issue_cycles counter port.
// Revision : 1.0 - initial release
// ============================================================================
module benes_cfg_sequencer #(
   parameter int  DATA_TYPE = 16,
   parameter int  NUM_PES   = 8,
   parameter int  LEVELS    = 7,
   parameter int  DEPTH     = 4,
   localparam int MUX_W     = 2*(LEVELS-2)*NUM_PES + NUM_PES,
   localparam int DATA_W    = NUM_PES*DATA_TYPE,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data_bus,
   input  logic [MUX_W-1:0]  i_mux_bus,
   input  logic [7:0]        i_repeat,
   input  logic              i_stall,
   output logic [DATA_W-1:0] o_data_bus,
   output logic [MUX_W-1:0]  o_mux_bus,
   output logic              o_valid,
   output logic              o_last,
   output logic [CNT_W-1:0]  o_count
`ifdef BENES_CFG_SEQ_PERF_EN
   ,
   output logic [31:0]       o_issue_cycles
`endif
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_data_mem [DEPTH];
   logic [MUX_W-1:0]  r_mux_mem  [DEPTH];
   logic [7:0]        r_rep_mem  [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [7:0]        r_rcnt, w_rcnt_nxt;
   logic [DATA_W-1:0] r_data;
   logic [MUX_W-1:0]  r_mux;
   logic              w_full, w_empty, w_push, w_pop;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = i_valid && !w_full;

   // Storage carries no reset; occupancy and pointers define what is live.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_data_mem[r_wr_ptr] <= i_data_bus;
         r_mux_mem[r_wr_ptr]  <= i_mux_bus;
         r_rep_mem[r_wr_ptr]  <= i_repeat;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // The FSM only ever inspects registered occupancy, so a fresh push into an
   // empty FIFO becomes eligible one edge later.
   always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !i_stall) begin
               w_pop       = 1'b1;
               w_rcnt_nxt  = r_rep_mem[r_rd_ptr];
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!i_stall) begin
               if (r_rcnt != 8'd0) begin
                  w_rcnt_nxt = r_rcnt - 8'd1;
               end else if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_rcnt_nxt = r_rep_mem[r_rd_ptr];
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rcnt  <= '0;
         r_data  <= '0;
         r_mux   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rcnt  <= w_rcnt_nxt;
         if (w_pop) begin
            r_data <= r_data_mem[r_rd_ptr];
            r_mux  <= r_mux_mem[r_rd_ptr];
         end
      end
   end

   assign o_ready    = !w_full;
   assign o_count    = r_count;
   assign o_valid    = (r_state == S_ISSUE);
   assign o_last     = o_valid && (r_rcnt == 8'd0);
   // Configuration is held while idle so the network does not toggle.
   assign o_data_bus = o_valid ? r_data : '0;
   assign o_mux_bus  = r_mux;

`ifdef BENES_CFG_SEQ_PERF_EN
   logic [31:0] r_issue_cycles;

   always_ff @(posedge CLK) begin
      if (rst)                      r_issue_cycles <= '0;
      else if (o_valid && !i_stall) r_issue_cycles <= r_issue_cycles + 32'd1;
   end

   assign o_issue_cycles = r_issue_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_benes_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_benes_cfg_sequencer
// Purpose  : Directed vector table, stall corner sequence and randomized run
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_benes_cfg_sequencer;
   localparam int DT = 16;
   localparam int NP = 8;
   localparam int LV = 7;
   localparam int DP = 4;
   localparam int MW = 2*(LV-2)*NP + NP;
   localparam int DW = NP*DT;

   logic          CLK = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic          i_stall = 1'b0;
   logic [DW-1:0] i_data_bus = '0;
   logic [MW-1:0] i_mux_bus = '0;
   logic [7:0]    i_repeat = '0;
   logic          o_ready, o_valid, o_last;
   logic [DW-1:0] o_data_bus;
   logic [MW-1:0] o_mux_bus;
   logic [2:0]    o_count;

   always #5 CLK = ~CLK;

   benes_cfg_sequencer #(.DATA_TYPE(DT), .NUM_PES(NP), .LEVELS(LV), .DEPTH(DP)) dut (
      .CLK(CLK), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_data_bus(i_data_bus), .i_mux_bus(i_mux_bus), .i_repeat(i_repeat),
      .i_stall(i_stall), .o_data_bus(o_data_bus), .o_mux_bus(o_mux_bus),
      .o_valid(o_valid), .o_last(o_last), .o_count(o_count)
   );

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [DW-1:0] data_of(input int id);
      case (id)
         0:       return '0;
         1:       return 128'h7777_6666_5555_4444_3333_2222_1111_0000;
         default: return {NP{16'(id * 16'h0101)}};
      endcase
   endfunction

   function automatic logic [MW-1:0] mux_of(input int id);
      case (id)
         0, 2:    return '0;
         1:       return {MW{1'b1}};
         3:       return {8'hFF, 80'h0};
         default: return {11{8'(id)}};
      endcase
   endfunction

   task automatic check(input string tag, input logic ev, input logic el,
                        input logic [DW-1:0] ed, input logic [MW-1:0] em,
                        input logic [2:0] ec, input logic er);
      logic bad;
      bad = 1'b0;
      vectors++;
      if (o_valid !== ev) begin $display("FAIL %s o_valid got %0b want %0b", tag, o_valid, ev); bad = 1'b1; end
      if (o_last !== el) begin $display("FAIL %s o_last got %0b want %0b", tag, o_last, el); bad = 1'b1; end
      if (o_data_bus !== ed) begin $display("FAIL %s o_data_bus got %h want %h", tag, o_data_bus, ed); bad = 1'b1; end
      if (o_mux_bus !== em) begin $display("FAIL %s o_mux_bus got %h want %h", tag, o_mux_bus, em); bad = 1'b1; end
      if (o_count !== ec) begin $display("FAIL %s o_count got %0d want %0d", tag, o_count, ec); bad = 1'b1; end
      if (o_ready !== er) begin $display("FAIL %s o_ready got %0b want %0b", tag, o_ready, er); bad = 1'b1; end
      if (bad) miscompares++;
   endtask

   // Directed vector: inputs before an edge, expected outputs after it.
   typedef struct {
      logic r, v, s;
      int   id, rep;
      logic ev, el;
      int   eid, emid, ec;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic r, input logic v, input logic s, input int id, input int rep,
                               input logic ev, input logic el, input int eid, input int emid, input int ec);
      vec_t x;
      x.r = r; x.v = v; x.s = s; x.id = id; x.rep = rep;
      x.ev = ev; x.el = el; x.eid = eid; x.emid = emid; x.ec = ec;
      tbl.push_back(x);
   endfunction

   // Reference model: queue of pending entries plus the entry being shown.
   typedef struct {
      logic [DW-1:0] data;
      logic [MW-1:0] mux;
      int            rep;
   } ent_t;
   ent_t          q[$];
   ent_t          cur, nw;
   logic          m_busy;
   int            m_left;
   logic [MW-1:0] m_mux;
   logic          r_in, v_in, s_in, acc;
   logic [3:0]    vseq, lseq;
   logic [3:0]    stall_pat;

   initial begin
      // reset
      add(1,0,0, 0,0,  0,0, 0,0, 0);
      add(1,0,0, 0,0,  0,0, 0,0, 0);
      // single entry
      add(0,1,0, 1,0,  0,0, 0,0, 1);
      add(0,0,0, 0,0,  1,1, 1,1, 0);
      add(0,0,0, 0,0,  0,0, 0,1, 0);
      // back-to-back
      add(0,1,0, 1,0,  0,0, 0,1, 1);
      add(0,1,0, 2,0,  1,1, 1,1, 1);
      add(0,1,0, 3,0,  1,1, 2,2, 1);
      add(0,0,0, 0,0,  1,1, 3,3, 0);
      add(0,0,0, 0,0,  0,0, 0,3, 0);
      // repeat = 3
      add(0,1,0, 4,3,  0,0, 0,3, 1);
      add(0,0,0, 0,0,  1,0, 4,4, 0);
      add(0,0,0, 0,0,  1,0, 4,4, 0);
      add(0,0,0, 0,0,  1,0, 4,4, 0);
      add(0,0,0, 0,0,  1,1, 4,4, 0);
      add(0,0,0, 0,0,  0,0, 0,4, 0);
      // fill under stall, fifth push dropped
      add(0,1,1, 5,0,  0,0, 0,4, 1);
      add(0,1,1, 6,0,  0,0, 0,4, 2);
      add(0,1,1, 7,0,  0,0, 0,4, 3);
      add(0,1,1, 8,0,  0,0, 0,4, 4);
      add(0,1,1, 9,0,  0,0, 0,4, 4);
      add(0,0,0, 0,0,  1,1, 5,5, 3);
      add(0,0,0, 0,0,  1,1, 6,6, 2);
      add(0,0,0, 0,0,  1,1, 7,7, 1);
      add(0,0,0, 0,0,  1,1, 8,8, 0);
      add(0,0,0, 0,0,  0,0, 0,8, 0);
      // reset during second cycle of a repeat=5 entry with 2 queued
      add(0,1,0,10,5,  0,0, 0,8, 1);
      add(0,1,0,11,0,  1,0,10,10,1);
      add(0,1,0,12,0,  1,0,10,10,2);
      add(1,0,0, 0,0,  0,0, 0,0, 0);
      add(0,0,0, 0,0,  0,0, 0,0, 0);
      add(0,0,0, 0,0,  0,0, 0,0, 0);

      foreach (tbl[k]) begin
         rst        = tbl[k].r;
         i_valid    = tbl[k].v;
         i_stall    = tbl[k].s;
         i_data_bus = data_of(tbl[k].id);
         i_mux_bus  = mux_of(tbl[k].id);
         i_repeat   = 8'(tbl[k].rep);
         @(posedge CLK); #1;
         check($sformatf("tbl[%0d]", k), tbl[k].ev, tbl[k].el, data_of(tbl[k].eid),
               mux_of(tbl[k].emid), 3'(tbl[k].ec), tbl[k].ec < DP);
      end

      // Stall in the middle of a repeat=1 entry stretches it by one cycle.
      rst = 1'b0; i_stall = 1'b0; i_valid = 1'b1;
      i_data_bus = data_of(13); i_mux_bus = mux_of(13); i_repeat = 8'd1;
      @(posedge CLK); #1;
      i_valid = 1'b0;
      stall_pat = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         i_stall = stall_pat[3-c];
         @(posedge CLK); #1;
         vseq[3-c] = o_valid;
         lseq[3-c] = o_last;
      end
      i_stall = 1'b0;
      vectors++;
      if (vseq !== 4'b1110 || lseq !== 4'b0010) begin
         $display("FAIL stall_stretch valid/last got %b/%b want 1110/0010", vseq, lseq);
         miscompares++;
      end

      // Randomized run against the reference model.
      rst = 1'b1; i_valid = 1'b0;
      @(posedge CLK); #1;
      q.delete(); m_busy = 1'b0; m_left = 0; m_mux = '0; cur.data = '0; cur.mux = '0; cur.rep = 0;
      for (int n = 0; n < 3000; n++) begin
         r_in = ($urandom_range(0, 199) == 0);
         v_in = ($urandom_range(0, 9) < 6);
         s_in = ($urandom_range(0, 9) < 2);
         nw.data = {$urandom, $urandom, $urandom, $urandom};
         nw.mux  = MW'({$urandom, $urandom, $urandom});
         nw.rep  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2));
         rst = r_in; i_valid = v_in; i_stall = s_in;
         i_data_bus = nw.data; i_mux_bus = nw.mux; i_repeat = 8'(nw.rep);
         @(posedge CLK);
         if (r_in) begin
            q.delete(); m_busy = 1'b0; m_left = 0; m_mux = '0;
         end else begin
            acc = v_in && (q.size() < DP);
            if (!s_in) begin
               if (m_busy) begin
                  m_left--;
                  if (m_left == 0) m_busy = 1'b0;
               end
               if (!m_busy && q.size() != 0) begin
                  cur = q.pop_front();
                  m_busy = 1'b1;
                  m_left = cur.rep + 1;
                  m_mux = cur.mux;
               end
            end
            if (acc) q.push_back(nw);
         end
         #1;
         check($sformatf("rand[%0d]", n), m_busy, m_busy && (m_left == 1),
               m_busy ? cur.data : '0, m_mux, 3'(q.size()), q.size() < DP);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
